// File: rtl/imm_gen_pipe.sv
// Decode-stage immediate generator: I/S/B/U/J/zimm/shamt decode stored in a 2-entry skid buffer.
// An entry pushed at edge N is presented after edge N; in_ready is registered so backpressure never drops an entry.
module imm_gen_pipe #(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            flush,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [31:0]     inst,
   input  logic [2:0]      imm_sel,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] imm,
   output logic            out_err
);

   if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
      $error("imm_gen_pipe: XLEN must be 32 or 64");
   end

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      FULL  = 2'd2
   } state_e;

   state_e          state_q, state_d;
   logic            in_ready_q;
   logic [XLEN-1:0] imm0_q, imm0_d, imm1_q, imm1_d, dec_imm;
   logic            err0_q, err0_d, err1_q, err1_d, dec_err;
   logic            push, pop;
   logic            unused_inst;

   // Opcode bits never contribute to any immediate.
   assign unused_inst = ^inst[6:0];

   assign push = in_valid & in_ready_q;
   assign pop  = out_valid & out_ready;

   // Sign-extended formats start from a sign fill and overwrite the low bits;
   // the top bit written is always inst[31], so the fill stays consistent.
   always_comb begin
      dec_imm = {XLEN{inst[31]}};
      dec_err = 1'b0;
      unique case (imm_sel)
         3'b000: dec_imm[11:0]  = inst[31:20];
         3'b001: dec_imm[11:0]  = {inst[31:25], inst[11:7]};
         3'b010: dec_imm[12:0]  = {inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
         3'b011: dec_imm[31:0]  = {inst[31:12], 12'b0};
         3'b100: dec_imm[20:0]  = {inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
         3'b101: begin
            dec_imm       = '0;
            dec_imm[4:0]  = inst[19:15];
         end
         3'b110: begin
            dec_imm       = '0;
            dec_imm[5:0]  = {((XLEN == 64) ? inst[25] : 1'b0), inst[24:20]};
         end
         3'b111: begin
            dec_imm = '0;
            dec_err = 1'b1;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= EMPTY;
         in_ready_q <= 1'b1;
      end else begin
         state_q    <= state_d;
         in_ready_q <= (state_d != FULL);
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         EMPTY: if (push) state_d = ONE;
         ONE: begin
            if (push && !pop)      state_d = FULL;
            else if (pop && !push) state_d = EMPTY;
         end
         FULL:    if (pop) state_d = ONE;
         default: state_d = EMPTY;
      endcase
      if (flush) state_d = EMPTY;
   end

   // Slot 0 is always the oldest entry and drives the outputs.
   always_comb begin
      out_valid = (state_q != EMPTY);
      imm0_d    = imm0_q;
      err0_d    = err0_q;
      imm1_d    = imm1_q;
      err1_d    = err1_q;
      case (state_q)
         EMPTY: begin
            if (push) begin
               imm0_d = dec_imm;
               err0_d = dec_err;
            end
         end
         ONE: begin
            if (push && pop) begin
               imm0_d = dec_imm;
               err0_d = dec_err;
            end else if (push) begin
               imm1_d = dec_imm;
               err1_d = dec_err;
            end
         end
         FULL: begin
            if (pop) begin
               imm0_d = imm1_q;
               err0_d = err1_q;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         imm0_q <= '0;
         err0_q <= 1'b0;
         imm1_q <= '0;
         err1_q <= 1'b0;
      end else begin
         imm0_q <= imm0_d;
         err0_q <= err0_d;
         imm1_q <= imm1_d;
         err1_q <= err1_d;
      end
   end

   assign in_ready = in_ready_q;
   assign imm      = imm0_q;
   assign out_err  = err0_q;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Bench for imm_gen_pipe: a 32-bit and a 64-bit instance, expected immediates queued at push, checked at pop.
module tb_imm_gen_pipe;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst, flush;
   logic        iv32, ir32, ov32, or32, oe32;
   logic [31:0] inst32, imm32;
   logic [2:0]  sel32;
   logic        iv64, ir64, ov64, or64, oe64;
   logic [31:0] inst64;
   logic [63:0] imm64;
   logic [2:0]  sel64;

   logic [31:0] x32_imm;
   logic        x32_err;
   logic [63:0] x64_imm;
   logic        x64_err;

   typedef struct packed {
      logic [63:0] imm;
      logic        err;
   } exp_t;

   exp_t q32[$];
   exp_t q64[$];
   exp_t e32, e64;
   int   nvec = 0, nerr = 0, pops32 = 0, pops64 = 0;

   imm_gen_pipe #(.XLEN(32)) d32 (
      .clk(clk), .rst(rst), .flush(flush),
      .in_valid(iv32), .in_ready(ir32), .inst(inst32), .imm_sel(sel32),
      .out_valid(ov32), .out_ready(or32), .imm(imm32), .out_err(oe32)
   );

   imm_gen_pipe #(.XLEN(64)) d64 (
      .clk(clk), .rst(rst), .flush(flush),
      .in_valid(iv64), .in_ready(ir64), .inst(inst64), .imm_sel(sel64),
      .out_valid(ov64), .out_ready(or64), .imm(imm64), .out_err(oe64)
   );

   // Scoreboards: handshakes are evaluated mid-cycle, pop checked before push.
   always @(negedge clk) begin
      if (rst || flush) begin
         q32.delete();
      end else begin
         if (ov32 && or32) begin
            pops32++;
            nvec++;
            if (q32.size() == 0) begin
               nerr++;
               $display("FAIL sb32_unexpected: got imm=%h err=%b, required no output", imm32, oe32);
            end else begin
               e32 = q32.pop_front();
               if (imm32 !== e32.imm[31:0] || oe32 !== e32.err) begin
                  nerr++;
                  $display("FAIL sb32_data: got imm=%h err=%b, required imm=%h err=%b",
                           imm32, oe32, e32.imm[31:0], e32.err);
               end
            end
         end
         if (iv32 && ir32) q32.push_back({32'h0, x32_imm, x32_err});
      end
   end

   always @(negedge clk) begin
      if (rst || flush) begin
         q64.delete();
      end else begin
         if (ov64 && or64) begin
            pops64++;
            nvec++;
            if (q64.size() == 0) begin
               nerr++;
               $display("FAIL sb64_unexpected: got imm=%h err=%b, required no output", imm64, oe64);
            end else begin
               e64 = q64.pop_front();
               if (imm64 !== e64.imm || oe64 !== e64.err) begin
                  nerr++;
                  $display("FAIL sb64_data: got imm=%h err=%b, required imm=%h err=%b",
                           imm64, oe64, e64.imm, e64.err);
               end
            end
         end
         if (iv64 && ir64) q64.push_back({x64_imm, x64_err});
      end
   end

   task automatic send32(input logic [31:0] i, input logic [2:0] s, input logic [31:0] ei, input logic ee);
      inst32 = i; sel32 = s; x32_imm = ei; x32_err = ee; iv32 = 1'b1;
      for (int n = 0; n < 20 && !ir32; n++) begin
         @(posedge clk); #1;
      end
      if (!ir32) begin
         nvec++; nerr++;
         $display("FAIL send32_timeout: in_ready=%b, required 1", ir32);
      end
      @(posedge clk); #1;
      iv32 = 1'b0;
   endtask

   task automatic send64(input logic [31:0] i, input logic [2:0] s, input logic [63:0] ei, input logic ee);
      inst64 = i; sel64 = s; x64_imm = ei; x64_err = ee; iv64 = 1'b1;
      for (int n = 0; n < 20 && !ir64; n++) begin
         @(posedge clk); #1;
      end
      if (!ir64) begin
         nvec++; nerr++;
         $display("FAIL send64_timeout: in_ready=%b, required 1", ir64);
      end
      @(posedge clk); #1;
      iv64 = 1'b0;
   endtask

   task automatic drain();
      for (int n = 0; n < 20 && (q32.size() != 0 || q64.size() != 0); n++) begin
         @(posedge clk); #1;
      end
      nvec++;
      if (q32.size() != 0 || q64.size() != 0) begin
         nerr++;
         $display("FAIL drain: pending q32=%0d q64=%0d, required 0 and 0", q32.size(), q64.size());
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; flush = 1'b0;
      iv32 = 0; or32 = 0; inst32 = '0; sel32 = '0; x32_imm = '0; x32_err = 0;
      iv64 = 0; or64 = 0; inst64 = '0; sel64 = '0; x64_imm = '0; x64_err = 0;
      repeat (2) @(posedge clk);
      #1;
      nvec++;
      if ({ov32, ir32, oe32, imm32} !== {1'b0, 1'b1, 1'b0, 32'h0}) begin
         nerr++;
         $display("FAIL reset32: got v=%b r=%b e=%b imm=%h, required 0 1 0 0", ov32, ir32, oe32, imm32);
      end
      nvec++;
      if ({ov64, ir64, oe64, imm64} !== {1'b0, 1'b1, 1'b0, 64'h0}) begin
         nerr++;
         $display("FAIL reset64: got v=%b r=%b e=%b imm=%h, required 0 1 0 0", ov64, ir64, oe64, imm64);
      end
      rst = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      nvec++;
      if (ir32 !== 1'b1 || ov32 !== 1'b0) begin
         nerr++;
         $display("FAIL idle32: got in_ready=%b out_valid=%b, required 1 0", ir32, ov32);
      end
   endtask

   task automatic test_isb();
      or32 = 1'b1;
      send32(32'hFFF00093, 3'b000, 32'hFFFFFFFF, 1'b0);
      nvec++;
      if (ov32 !== 1'b1 || imm32 !== 32'hFFFFFFFF) begin
         nerr++;
         $display("FAIL latency_i: got v=%b imm=%h, required 1 ffffffff", ov32, imm32);
      end
      send32(32'hFE512E23, 3'b001, 32'hFFFFFFFC, 1'b0);
      send32(32'hFE000CE3, 3'b010, 32'hFFFFFFF8, 1'b0);
      drain();
   endtask

   task automatic test_ujzsh();
      logic [31:0] ti [4];
      logic [2:0]  ts [4];
      logic [31:0] te [4];
      int          p;
      ti = '{32'h123450B7, 32'h001000EF, 32'h340FD073, 32'h41F0D093};
      ts = '{3'b011, 3'b100, 3'b101, 3'b110};
      te = '{32'h12345000, 32'h00000800, 32'h0000001F, 32'h0000001F};
      p = pops32;
      or32 = 1'b1;
      for (int k = 0; k < 4; k++) send32(ti[k], ts[k], te[k], 1'b0);
      drain();
      nvec++;
      if (pops32 - p != 4) begin
         nerr++;
         $display("FAIL ujzsh_count: got %0d outputs, required 4", pops32 - p);
      end
   endtask

   task automatic test_xlen64();
      or64 = 1'b1;
      send64(32'hFFF00093, 3'b000, 64'hFFFFFFFFFFFFFFFF, 1'b0);
      send64(32'h800000B7, 3'b011, 64'hFFFFFFFF80000000, 1'b0);
      send64(32'h03F01093, 3'b110, 64'h000000000000003F, 1'b0);
      send64(32'hFFF00093, 3'b111, 64'h0, 1'b1);
      drain();
   endtask

   task automatic test_backpressure();
      int p;
      p = pops32;
      or32 = 1'b0;
      send32(32'hFFF00093, 3'b000, 32'hFFFFFFFF, 1'b0);
      send32(32'h123450B7, 3'b011, 32'h12345000, 1'b0);
      nvec++;
      if (ir32 !== 1'b0) begin
         nerr++;
         $display("FAIL bp_full_ready: got in_ready=%b, required 0", ir32);
      end
      inst32 = 32'hFE512E23; sel32 = 3'b001; x32_imm = 32'hFFFFFFFC; x32_err = 1'b0; iv32 = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(posedge clk); #1;
         nvec++;
         if (ov32 !== 1'b1 || imm32 !== 32'hFFFFFFFF || oe32 !== 1'b0 || ir32 !== 1'b0) begin
            nerr++;
            $display("FAIL bp_hold: got v=%b imm=%h e=%b r=%b, required 1 ffffffff 0 0", ov32, imm32, oe32, ir32);
         end
      end
      or32 = 1'b1;
      for (int n = 0; n < 20 && !ir32; n++) begin
         @(posedge clk); #1;
      end
      @(posedge clk); #1;
      iv32 = 1'b0;
      drain();
      nvec++;
      if (pops32 - p != 3) begin
         nerr++;
         $display("FAIL bp_count: got %0d outputs, required 3", pops32 - p);
      end
   endtask

   task automatic test_flush();
      int p;
      or32 = 1'b0;
      send32(32'hFFF00093, 3'b000, 32'hFFFFFFFF, 1'b0);
      send32(32'h123450B7, 3'b011, 32'h12345000, 1'b0);
      inst32 = 32'h001000EF; sel32 = 3'b100; x32_imm = 32'h800; iv32 = 1'b1; flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0; iv32 = 1'b0;
      nvec++;
      if (ov32 !== 1'b0 || ir32 !== 1'b1) begin
         nerr++;
         $display("FAIL flush_full: got v=%b r=%b, required 0 1", ov32, ir32);
      end
      send32(32'hFE512E23, 3'b001, 32'hFFFFFFFC, 1'b0);
      inst32 = 32'h001000EF; sel32 = 3'b100; x32_imm = 32'h800; iv32 = 1'b1; flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0; iv32 = 1'b0;
      nvec++;
      if (ov32 !== 1'b0 || ir32 !== 1'b1) begin
         nerr++;
         $display("FAIL flush_one: got v=%b r=%b, required 0 1", ov32, ir32);
      end
      p = pops32;
      or32 = 1'b1;
      repeat (4) @(posedge clk);
      #1;
      nvec++;
      if (pops32 != p) begin
         nerr++;
         $display("FAIL flush_leak: got %0d outputs, required 0", pops32 - p);
      end
   endtask

   task automatic test_reset_mid();
      int p;
      or32 = 1'b0;
      send32(32'hFFF00093, 3'b000, 32'hFFFFFFFF, 1'b0);
      send32(32'hFFF00093, 3'b111, 32'h0, 1'b1);
      inst32 = 32'h001000EF; sel32 = 3'b100; x32_imm = 32'h800; iv32 = 1'b1;
      rst = 1'b1; or32 = 1'b1;
      @(posedge clk); #1;
      nvec++;
      if ({ov32, ir32, oe32, imm32} !== {1'b0, 1'b1, 1'b0, 32'h0}) begin
         nerr++;
         $display("FAIL reset_mid: got v=%b r=%b e=%b imm=%h, required 0 1 0 0", ov32, ir32, oe32, imm32);
      end
      or32 = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0; iv32 = 1'b0;
      p = pops32;
      or32 = 1'b1;
      send32(32'h123450B7, 3'b011, 32'h12345000, 1'b0);
      drain();
      nvec++;
      if (pops32 - p != 1) begin
         nerr++;
         $display("FAIL reset_resume: got %0d outputs, required 1", pops32 - p);
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_isb();
      test_ujzsh();
      test_xlen64();
      test_backpressure();
      test_flush();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
